// File: rtl/ysyx_23060332_dmem_pkg.sv
// Shared types for the data-memory responder: FSM states and size-mask encodings.
// Combinational helper only; no latency or backpressure of its own.
package ysyx_23060332_dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;

    // Byte lanes touched by a right-justified access; lanes pushed past byte 3 fall off.
    function automatic logic [3:0] lane_en(input logic [3:0] mask, input logic [1:0] off);
        return mask << off;
    endfunction

endpackage

// File: rtl/ysyx_23060332_dmem_sram.sv
// Word-organised storage with per-byte write enables; synchronous write, combinational read.
// Single-cycle write, zero-cycle read; never stalls.
module ysyx_23060332_dmem_sram #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic [3:0]               we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/ysyx_23060332_dmem_resp.sv
// Load/store responder: accept one request, answer LATENCY cycles later, hold until resp_ready.
// Optional alignment/range checking under YSYX_23060332_DMEM_ALIGN_CHK_EN.
module ysyx_23060332_dmem_resp
    import ysyx_23060332_dmem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_ren,
    input  logic [31:0] mem_raddr,
    input  logic        mem_wen,
    input  logic [31:0] mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic [7:0]  mem_wmask,
    output logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ren_q, ren_d, wen_q, wen_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0]   rel;
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [4:0]    sh;
    logic [31:0]   sram_rdata;
    logic [3:0]    sram_we;
    logic          align_err;
    logic          acc_err;
    logic          access_now;
    logic          unused_bits;

    assign rel = addr_q - BASE_ADDR;
    assign idx = rel[AW+1:2];
    assign off = addr_q[1:0];
    assign sh  = {off, 3'b000};

`ifdef YSYX_23060332_DMEM_ALIGN_CHK_EN
    assign align_err = ((mask_q == MASK_H[3:0]) && off[0])
                    || ((mask_q == MASK_W[3:0]) && (off != 2'b00))
                    || (rel >= 32'(DEPTH * 4));
`else
    assign align_err = 1'b0;
`endif

    assign unused_bits = ^{mem_wmask[7:4], rel[31:AW+2]};

    assign acc_err    = align_err && (ren_q || wen_q);
    assign access_now = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    // Gate on rst so a store whose access edge coincides with reset is discarded.
    assign sram_we    = (access_now && wen_q && !acc_err && !rst) ? lane_en(mask_q, off) : 4'b0000;

    ysyx_23060332_dmem_sram #(
        .DEPTH (DEPTH)
    ) u_sram (
        .clk   (clk),
        .we    (sram_we),
        .idx   (idx),
        .wdata (wdata_q << sh),
        .rdata (sram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    ren_d   = mem_ren;
                    wen_d   = mem_wen;
                    addr_d  = mem_wen ? mem_waddr : mem_raddr;
                    wdata_d = mem_wdata;
                    mask_d  = mem_wmask[3:0];
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = (ren_q && !wen_q && !acc_err) ? (sram_rdata >> sh) : 32'd0;
                    err_d   = acc_err;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            mask_q  <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign mem_rdata  = rdata_q;
    assign resp_err   = err_q;

endmodule
